// File: rtl/output_drain_ctrl.sv
// Snapshots one row of PE lane results, pushes them serially into the SIPO, then pops it and commits the word.
// Optional build macro OUTPUT_DRAIN_RELU_EN clamps negative lanes to zero at capture.
module output_drain_ctrl #(
  parameter int NUM_PE     = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic                         i_clear,
  input  logic                         i_start,
  input  logic [NUM_PE-1:0]            i_pe_valid,
  input  logic [NUM_PE*DATA_WIDTH-1:0] i_pe_data,
  input  logic                         i_sipo_full,
  output logic                         o_sipo_wen,
  output logic [DATA_WIDTH-1:0]        o_sipo_data,
  output logic                         o_sipo_ren,
  output logic                         o_sipo_clear,
  output logic                         o_buf_wen,
  output logic [ADDR_WIDTH-1:0]        o_buf_addr,
  output logic                         o_busy,
  output logic                         o_done
);
  localparam int CW = $clog2(NUM_PE) + 1;
  localparam int IW = CW - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, POP, WRITE} state_e;

  state_e                             state_q, state_d;
  logic [CW-1:0]                      lane_cnt_q, lane_cnt_d;
  logic [NUM_PE-1:0][DATA_WIDTH-1:0]  cap_q, cap_d;
  logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
  logic [NUM_PE-1:0][DATA_WIDTH-1:0]  lane_in;
  logic [IW-1:0]                      lane_sel;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] raw;
    assign raw = i_pe_valid[g] ? i_pe_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;
`ifdef OUTPUT_DRAIN_RELU_EN
    assign lane_in[g] = raw[DATA_WIDTH-1] ? '0 : raw;
`else
    assign lane_in[g] = raw;
`endif
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      cap_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      cap_q      <= cap_d;
      addr_q     <= addr_d;
    end
  end

  // Clear overrides everything, including a start in the same cycle.
  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    cap_d      = cap_q;
    addr_d     = addr_q;
    if (i_clear) begin
      state_d    = IDLE;
      lane_cnt_d = '0;
      addr_d     = '0;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          cap_d      = lane_in;
          lane_cnt_d = '0;
          state_d    = SHIFT;
        end
        SHIFT: begin
          lane_cnt_d = lane_cnt_q + 1'b1;
          if (lane_cnt_q == CW'(NUM_PE - 1)) state_d = POP;
        end
        POP: if (i_sipo_full) state_d = WRITE;
        WRITE: begin
          addr_d     = addr_q + 1'b1;
          lane_cnt_d = '0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_sipo_wen   = 1'b0;
    o_sipo_ren   = 1'b0;
    o_sipo_clear = 1'b0;
    o_buf_wen    = 1'b0;
    o_done       = 1'b0;
    if (i_clear) begin
      o_sipo_clear = 1'b1;
    end else begin
      case (state_q)
        SHIFT: o_sipo_wen = 1'b1;
        POP:   o_sipo_ren = i_sipo_full;
        WRITE: begin
          o_buf_wen    = 1'b1;
          o_done       = 1'b1;
          o_sipo_clear = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // lane_cnt reaches NUM_PE after the last push; that value selects nothing.
  assign lane_sel    = lane_cnt_q[IW-1:0];
  assign o_sipo_data = (state_q != IDLE && lane_cnt_q < CW'(NUM_PE)) ? cap_q[lane_sel] : '0;
  assign o_busy      = (state_q != IDLE);
  assign o_buf_addr  = addr_q;
endmodule

// File: tb/tb_output_drain_ctrl.sv
// Self-checking bench for output_drain_ctrl: vector table, random rows vs a lane model, clear/reset/wrap sequences.
module tb_output_drain_ctrl;
  localparam int NP = 8, DW = 16, AW = 10;
`ifdef OUTPUT_DRAIN_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic i_clk = 1'b0, i_nrst = 1'b0, i_clear = 1'b0, i_start = 1'b0;
  logic [NP-1:0]    i_pe_valid = '0;
  logic [NP*DW-1:0] i_pe_data  = '0;
  logic             i_sipo_full;
  logic             o_sipo_wen, o_sipo_ren, o_sipo_clear, o_buf_wen, o_busy, o_done;
  logic [DW-1:0]    o_sipo_data;
  logic [AW-1:0]    o_buf_addr;

  output_drain_ctrl #(.NUM_PE(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_clear(i_clear), .i_start(i_start),
    .i_pe_valid(i_pe_valid), .i_pe_data(i_pe_data), .i_sipo_full(i_sipo_full),
    .o_sipo_wen(o_sipo_wen), .o_sipo_data(o_sipo_data), .o_sipo_ren(o_sipo_ren),
    .o_sipo_clear(o_sipo_clear), .o_buf_wen(o_buf_wen), .o_buf_addr(o_buf_addr),
    .o_busy(o_busy), .o_done(o_done));

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_err = 0;
  int exp_addr = 0, exp_writes = 0, seen_writes = 0;
  int sipo_cnt;
  logic hold_full = 1'b0;

  // SIPO stand-in: counts pushes, reports full after NUM_PE unless the test holds it off.
  always @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) sipo_cnt <= 0;
    else if (o_sipo_clear) sipo_cnt <= 0;
    else if (o_sipo_wen) sipo_cnt <= sipo_cnt + 1;
  assign i_sipo_full = (sipo_cnt >= NP) && !hold_full;

  always @(posedge i_clk) if (o_buf_wen) seen_writes <= seen_writes + 1;

  typedef logic [NP-1:0][DW-1:0] row_t;
  typedef struct {
    logic [NP-1:0] mask;
    row_t          d;
    int            hold;
    row_t          e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane_val(input logic v, input logic [DW-1:0] d);
    if (!v) return '0;
    if (RELU && d[DW-1]) return '0;
    return d;
  endfunction

  task automatic run_row(input logic [NP-1:0] mask, input row_t d, input int hold,
                         input bit poke_start, input row_t expv);
    @(negedge i_clk);
    i_pe_valid = mask; i_pe_data = d; i_start = 1'b1; hold_full = (hold > 0);
    @(negedge i_clk);
    i_start = 1'b0;
    i_pe_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    i_pe_valid = NP'($urandom());
    for (int k = 0; k < NP; k++) begin
      chk("push_wen", 32'(o_sipo_wen), 32'd1);
      chk("push_data", 32'(o_sipo_data), 32'(expv[k]));
      chk("push_busy", 32'(o_busy), 32'd1);
      if (poke_start && k == 3) i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
    end
    for (int h = 0; h < hold; h++) begin
      chk("pop_wait_ren", 32'(o_sipo_ren), 32'd0);
      chk("pop_wait_busy", 32'(o_busy), 32'd1);
      chk("pop_wait_wen", 32'(o_sipo_wen), 32'd0);
      @(negedge i_clk);
    end
    hold_full = 1'b0;
    #1;
    chk("pop_ren", 32'(o_sipo_ren), 32'd1);
    chk("pop_bufwen", 32'(o_buf_wen), 32'd0);
    @(negedge i_clk);
    chk("wr_bufwen", 32'(o_buf_wen), 32'd1);
    chk("wr_done", 32'(o_done), 32'd1);
    chk("wr_sclear", 32'(o_sipo_clear), 32'd1);
    chk("wr_ren", 32'(o_sipo_ren), 32'd0);
    chk("wr_addr", 32'(o_buf_addr), 32'(exp_addr));
    exp_addr = (exp_addr + 1) % (1 << AW);
    exp_writes++;
    @(negedge i_clk);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_data", 32'(o_sipo_data), 32'd0);
    chk("idle_done", 32'(o_done), 32'd0);
    chk("idle_addr", 32'(o_buf_addr), 32'(exp_addr));
  endtask

  task automatic rand_row(input int hold, input bit poke);
    row_t d, e;
    logic [NP-1:0] m;
    m = NP'($urandom());
    for (int i = 0; i < NP; i++) begin
      d[i] = DW'($urandom());
      e[i] = lane_val(m[i], d[i]);
    end
    run_row(m, d, hold, poke, e);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{8'hFF, {16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1}, 0,
               {16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1}};
    tbl[1] = '{8'h0F, {8{16'h1111}}, 0, {{4{16'h0000}}, {4{16'h1111}}}};
    tbl[2] = '{8'hFF, {16'h17,16'h16,16'h15,16'h14,16'h13,16'h12,16'h11,16'h10}, 5,
               {16'h17,16'h16,16'h15,16'h14,16'h13,16'h12,16'h11,16'h10}};
    tbl[3] = '{8'h03, {{6{16'h1234}}, 16'd7, 16'hFFFB}, 0,
               RELU ? {{6{16'h0}}, 16'd7, 16'h0000} : {{6{16'h0}}, 16'd7, 16'hFFFB}};
    tbl[4] = '{8'h00, {8{16'hABCD}}, 2, {8{16'h0000}}};

    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_addr", 32'(o_buf_addr), 32'd0);
    chk("rst_strobes", 32'({o_sipo_wen, o_sipo_ren, o_sipo_clear, o_buf_wen, o_done}), 32'd0);
    chk("rst_data", 32'(o_sipo_data), 32'd0);
    @(negedge i_clk); @(negedge i_clk);
    i_nrst = 1'b1;

    foreach (tbl[i]) run_row(tbl[i].mask, tbl[i].d, tbl[i].hold, 1'b0, tbl[i].e);
    for (int r = 0; r < 20; r++) rand_row(int'($urandom_range(0, 3)), r[0]);

    // Clear on the third SHIFT cycle.
    @(negedge i_clk);
    i_pe_valid = 8'hFF; i_pe_data = {8{16'h5555}}; i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_clear = 1'b1; #1;
    chk("clr_sclear", 32'(o_sipo_clear), 32'd1);
    chk("clr_other", 32'({o_sipo_wen, o_sipo_ren, o_buf_wen, o_done}), 32'd0);
    @(negedge i_clk); i_clear = 1'b0;
    chk("clr_idle", 32'(o_busy), 32'd0);
    chk("clr_addr", 32'(o_buf_addr), 32'd0);
    exp_addr = 0;
    i_start = 1'b1; i_clear = 1'b1;
    @(negedge i_clk); i_start = 1'b0; i_clear = 1'b0;
    chk("start_clr_drop", 32'(o_busy), 32'd0);
    rand_row(0, 1'b0);

    // Walk the address to the top and across the wrap, poking start while busy.
    while (exp_addr != (1 << AW) - 1) rand_row(0, exp_addr[2]);
    chk("addr_top", 32'(o_buf_addr), 32'd1023);
    rand_row(1, 1'b1);
    chk("addr_wrap", 32'(o_buf_addr), 32'd0);
    rand_row(0, 1'b0);

    // Async reset in the middle of a row.
    @(negedge i_clk);
    i_pe_valid = 8'hFF; i_pe_data = {8{16'h0F0F}}; i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    @(negedge i_clk);
    i_nrst = 1'b0; #1;
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_addr", 32'(o_buf_addr), 32'd0);
    chk("arst_wen", 32'(o_sipo_wen), 32'd0);
    @(negedge i_clk); i_nrst = 1'b1;
    exp_addr = 0;
    rand_row(0, 1'b0);

    @(negedge i_clk);
    chk("buf_write_count", 32'(seen_writes), 32'(exp_writes));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
